axis_pipe_slice: RTL and testbench
==================================

# axis_pipe_slice

Parametrised multi-stage AXIS register pipeline for timing closure on long inter-module routes in the accelerator datapath. It chains `STAGE_N` full-throughput skid stages, each of which registers both the forward path (payload/valid) and the backward path (ready). It adds a synchronous flush and an optional occupancy counter. It sits between any AXIS master/slave pair, e.g. between the feature-map DMA and the convolution buffers.

## Interface
- `DATA_WIDTH`, 32, tdata width; must be a multiple of 8
- `USER_WIDTH`, 1, tuser width; ≥1, leave unconnected when unused
- `STAGE_N`, 2, number of pipeline stages; 1..8
- `EN_READY`, 1, 1 = full handshake with skid stages; 0 = ready ignored, plain valid delay line
- `SIM_DELAY`, 1, non-blocking assignment delay for simulation
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `flush`  in  1  synchronous drop of all buffered beats
- `s_axis_data`  in  DATA_WIDTH  slave payload
- `s_axis_keep`  in  DATA_WIDTH/8  slave byte enables
- `s_axis_user`  in  USER_WIDTH  slave user
- `s_axis_last`  in  1  slave last
- `s_axis_valid`  in  1  slave valid
- `s_axis_ready`  out  1  slave ready; registered
- `m_axis_data` / `_keep` / `_user` / `_last`  out  as slave  master payload; registered
- `m_axis_valid`  out  1  master valid; registered
- `m_axis_ready`  in  1  master ready
- `occupancy`  out  $clog2(2*STAGE_N+1)  number of beats held (see Configuration)

## Operation
- Payload is bundled as {data, keep, user, last} and treated opaquely.
- Each stage has a main register and a skid register, each with its own valid bit.
- Stage states: EMPTY (both invalid), BUSY (main valid), FULL (main and skid valid). Per-stage `in` is upstream valid & stage ready. Per-stage `out` is stage valid & downstream ready.
- EMPTY: `in` → load main, go to BUSY.
- BUSY:
  - `in` & `out` → load main, stay in BUSY.
  - `in` & !`out` → load skid, go to FULL.
  - !`in` & `out` → go to EMPTY.
- FULL: stage ready = 0. `out` → main ← skid, go to BUSY.
- Stage ready = !skid_valid, taken directly from a flop. No combinational path from `m_axis_ready` to `s_axis_ready`.
- Stage k's downstream is stage k+1. The last stage drives `m_axis_*`; stage 0 drives `s_axis_ready`.
- Beat order is strictly preserved. No beat is ever duplicated or dropped, except on `flush` or `rst`.
- `EN_READY`=0:
  - Skid registers are not built; `s_axis_ready` = 1.
  - `m_axis_ready` is ignored.
  - Each stage captures payload when the upstream valid is 1 and shifts valid every cycle.
- `flush`=1:
  - All valid bits clear at the next edge; payload registers are not cleared.
  - A beat presented on `s_axis` in the same cycle is dropped, even if `s_axis_ready`=1.
  - `flush` has priority over all transitions.

## Timing
- Reset values: `m_axis_valid`=0; `s_axis_ready`=1 (1 also for `EN_READY`=0); `occupancy`=0. Payload outputs are undefined, since payload registers have no reset.
- `rst` asserted mid-transfer: identical to flush, and all in-flight beats are lost.
- Latency from accept to `m_axis_valid` with an empty pipe: `STAGE_N` cycles.
- Throughput: 1 beat/cycle sustained while `m_axis_ready`=1.
- Backpressure:
  - With `m_axis_ready` held 0, the pipe absorbs up to 2*`STAGE_N` beats.
  - `s_axis_ready` falls within `STAGE_N` cycles of stage 0 filling.
  - After `m_axis_ready` rises, `s_axis_ready` rises `STAGE_N` cycles later, at the latest.
- `m_axis_valid` never drops without a handshake, except on `flush`/`rst`. Payload is stable while valid & !ready.

## Configuration
- `AXIS_PIPE_SLICE_OCCUPANCY_EN` defined:
  - `occupancy` is a registered count of valid main plus skid entries.
  - It is +1 on `s` handshake, −1 on `m` handshake, unchanged when both occur, and 0 on `flush`/`rst`.
  - Range 0..2*`STAGE_N`; for `EN_READY`=0 the range is 0..`STAGE_N`.
- Undefined: the counter logic is not built, and `occupancy` is tied to 0.

## Test plan
- `STAGE_N`=3, `m_axis_ready`=1, beats 0x00..0x0F sent back-to-back → first beat on `m_axis` 3 cycles after accept; 16 beats arrive consecutively and in order; `s_axis_ready` stays 1.
- `STAGE_N`=2, `m_axis_ready`=0, continuous input → exactly 4 beats accepted; `s_axis_ready`=0; `occupancy`=4 (macro on); `m_axis_data`=first beat, held stable.
- Random `s_axis_valid`/`m_axis_ready` at 50% each, 10k beats with an incrementing data/last pattern → scoreboard shows no loss, duplication or reorder; `occupancy` equals the scoreboard depth every cycle.
- Pipe holding 3 beats, `flush` pulsed together with a new `s_axis` beat → `m_axis_valid`=0 next cycle; `occupancy`=0; flushed beat never appears; next beat sent passes normally.
- `rst` asserted for 1 cycle while full → next cycle `m_axis_valid`=0, `s_axis_ready`=1, `occupancy`=0.
- `EN_READY`=0, `STAGE_N`=4, `m_axis_ready`=0, valid pulse pattern 1,0,1,1 → same pattern on `m_axis_valid` 4 cycles later with matching payload; `s_axis_ready` constantly 1.

Source files
------------

// File: rtl/axis_pipe_slice_if.sv
// AXI-Stream bundle (data/keep/user/last + valid/ready) used on both sides of axis_pipe_slice.
// master drives payload and valid, slave drives ready.
interface axis_pipe_slice_if #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] keep;
    logic [USER_WIDTH-1:0]   user;
    logic                    last;
    logic                    valid;
    logic                    ready;

    modport master (
        output data, keep, user, last, valid,
        input  ready
    );

    modport slave (
        input  data, keep, user, last, valid,
        output ready
    );
endinterface

// File: rtl/axis_pipe_slice.sv
// STAGE_N-deep AXIS register slice; latency STAGE_N cycles, 1 beat/cycle; both valid and ready fully registered.
// Backpressure: each stage skids one beat (2*STAGE_N total); EN_READY=0 is a plain valid delay line. Occupancy counter: AXIS_PIPE_SLICE_OCCUPANCY_EN.
module axis_pipe_slice #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int STAGE_N    = 2,
    parameter int EN_READY   = 1,
    parameter int SIM_DELAY  = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    axis_pipe_slice_if.slave                   s_axis,
    axis_pipe_slice_if.master                  m_axis,
    output logic [$clog2(2*STAGE_N+1)-1:0]     occupancy
);
    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int PAY_W  = DATA_WIDTH + KEEP_W + USER_WIDTH + 1;
    localparam int OCC_W  = $clog2(2*STAGE_N+1);
    // Simulation-only NBA delay is not applied in this synthesizable model.
    localparam int unused_sim_delay = SIM_DELAY;

    typedef logic [PAY_W-1:0] pay_t;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b10,
        ST_FULL  = 2'b11
    } stage_e;

    // Index k is the boundary feeding stage k; index STAGE_N is the master port.
    logic [STAGE_N:0] vld;
    logic [STAGE_N:0] rdy;
    pay_t             dat [STAGE_N+1];

    assign vld[0]       = s_axis.valid;
    assign dat[0]       = {s_axis.data, s_axis.keep, s_axis.user, s_axis.last};
    assign rdy[STAGE_N] = m_axis.ready;

    assign s_axis.ready = rdy[0];
    assign m_axis.valid = vld[STAGE_N];
    assign {m_axis.data, m_axis.keep, m_axis.user, m_axis.last} = dat[STAGE_N];

    for (genvar k = 0; k < STAGE_N; k++) begin : g_stage
        logic main_vld_q, main_vld_d;
        pay_t main_q, main_d;

        if (EN_READY != 0) begin : g_skid
            logic skid_vld_q, skid_vld_d;
            pay_t skid_q, skid_d;
            logic in_hs, out_hs;

            always_comb begin
                in_hs      = vld[k] & ~skid_vld_q;
                out_hs     = main_vld_q & rdy[k+1];
                main_vld_d = main_vld_q;
                skid_vld_d = skid_vld_q;
                main_d     = main_q;
                skid_d     = skid_q;
                case ({main_vld_q, skid_vld_q})
                    ST_EMPTY: begin
                        if (in_hs) begin
                            main_d     = dat[k];
                            main_vld_d = 1'b1;
                        end
                    end
                    ST_BUSY: begin
                        if (in_hs && out_hs) begin
                            main_d = dat[k];
                        end else if (in_hs) begin
                            skid_d     = dat[k];
                            skid_vld_d = 1'b1;
                        end else if (out_hs) begin
                            main_vld_d = 1'b0;
                        end
                    end
                    ST_FULL: begin
                        if (out_hs) begin
                            main_d     = skid_q;
                            skid_vld_d = 1'b0;
                        end
                    end
                    default: begin
                        main_vld_d = 1'b0;
                        skid_vld_d = 1'b0;
                    end
                endcase
                if (flush) begin
                    main_vld_d = 1'b0;
                    skid_vld_d = 1'b0;
                end
            end

            // Payload flops carry no reset; only the valid bits are cleared.
            always_ff @(posedge clk) begin
                if (rst) begin
                    main_vld_q <= 1'b0;
                    skid_vld_q <= 1'b0;
                end else begin
                    main_vld_q <= main_vld_d;
                    skid_vld_q <= skid_vld_d;
                end
                main_q <= main_d;
                skid_q <= skid_d;
            end

            assign rdy[k] = ~skid_vld_q;
        end else begin : g_delay
            logic unused_dn_rdy;

            always_comb begin
                main_vld_d = vld[k] & ~flush;
                main_d     = vld[k] ? dat[k] : main_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    main_vld_q <= 1'b0;
                end else begin
                    main_vld_q <= main_vld_d;
                end
                main_q <= main_d;
            end

            assign rdy[k]        = 1'b1;
            assign unused_dn_rdy = rdy[k+1];
        end

        assign vld[k+1] = main_vld_q;
        assign dat[k+1] = main_q;
    end

`ifdef AXIS_PIPE_SLICE_OCCUPANCY_EN
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             s_hs, m_hs;

    always_comb begin
        s_hs  = vld[0] & rdy[0];
        // Without ready the beat leaves whenever the last stage is valid.
        m_hs  = vld[STAGE_N] & (rdy[STAGE_N] | (EN_READY == 0));
        occ_d = occ_q;
        if (s_hs && !m_hs) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!s_hs && m_hs) begin
            occ_d = occ_q - OCC_W'(1);
        end
        if (flush) begin
            occ_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`else
    assign occupancy = '0;
`endif
endmodule

// File: tb/tb_axis_pipe_slice.sv
// Directed bench for axis_pipe_slice: three instances (3-stage skid, 2-stage skid, 4-stage delay line).
// Outputs are sampled 1 time unit after the rising edge; inputs are driven at the same point.
module tb_axis_pipe_slice;
    localparam int DW = 32;
    localparam int UW = 1;
`ifdef AXIS_PIPE_SLICE_OCCUPANCY_EN
    localparam bit OCC_EN = 1'b1;
`else
    localparam bit OCC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       flush;
    logic [2:0] occ_a;
    logic [2:0] occ_b;
    logic [3:0] occ_c;

    axis_pipe_slice_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) sa ();
    axis_pipe_slice_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) ma ();
    axis_pipe_slice_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) sb ();
    axis_pipe_slice_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) mb ();
    axis_pipe_slice_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) sc ();
    axis_pipe_slice_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) mc ();

    axis_pipe_slice #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .STAGE_N(3), .EN_READY(1), .SIM_DELAY(1)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .s_axis(sa), .m_axis(ma), .occupancy(occ_a));
    axis_pipe_slice #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .STAGE_N(2), .EN_READY(1), .SIM_DELAY(1)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .s_axis(sb), .m_axis(mb), .occupancy(occ_b));
    axis_pipe_slice #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .STAGE_N(4), .EN_READY(0), .SIM_DELAY(1)) u_c (
        .clk(clk), .rst(rst), .flush(flush), .s_axis(sc), .m_axis(mc), .occupancy(occ_c));

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] occ_x(input int v);
        return OCC_EN ? 64'(v) : 64'd0;
    endfunction

    task automatic drive_a(input logic v, input logic [31:0] d, input logic l);
        sa.valid = v; sa.data = d; sa.keep = 4'hF; sa.user = d[0]; sa.last = l;
    endtask
    task automatic drive_b(input logic v, input logic [31:0] d);
        sb.valid = v; sb.data = d; sb.keep = 4'hF; sb.user = 1'b0; sb.last = d[0];
    endtask
    task automatic drive_c(input logic v, input logic [31:0] d);
        sc.valid = v; sc.data = d; sc.keep = 4'h3; sc.user = 1'b1; sc.last = 1'b0;
    endtask

    initial begin
        int          acc, del, got, exp_v, prev_v, n_sent, n_recv, cyc, e;
        logic        pend, s_hs, m_hs;
        logic [3:0]  pat;
        logic [31:0] exp_q[$];

        rst = 1'b1; flush = 1'b0;
        drive_a(0, 0, 0); drive_b(0, 0); drive_c(0, 0);
        ma.ready = 1'b0; mb.ready = 1'b0; mc.ready = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_a_mvld", ma.valid, 0);
        chk("rst_a_srdy", sa.ready, 1);
        chk("rst_a_occ", occ_a, 0);
        chk("rst_b_mvld", mb.valid, 0);
        chk("rst_b_srdy", sb.ready, 1);
        chk("rst_c_srdy", sc.ready, 1);
        chk("rst_c_mvld", mc.valid, 0);
        chk("rst_c_occ", occ_c, 0);

        // 3 stages, ready high, 16 back-to-back beats
        ma.ready = 1'b1;
        for (int c = 0; c < 21; c++) begin
            if (c < 16) drive_a(1, c, c == 15);
            else        drive_a(0, 0, 0);
            tick();
            exp_v = (c >= 2 && c < 18) ? 1 : 0;
            chk("t1_mvld", ma.valid, exp_v);
            if (exp_v == 1) begin
                chk("t1_data", ma.data, c - 2);
                chk("t1_last", ma.last, (c - 2) == 15);
                chk("t1_user", ma.user, (c - 2) % 2);
            end
            chk("t1_srdy", sa.ready, 1);
            acc = (c + 1 < 16) ? c + 1 : 16;
            del = (c - 2 < 0) ? 0 : ((c - 2 > 16) ? 16 : c - 2);
            chk("t1_occ", occ_a, occ_x(acc - del));
        end

        // 2 stages, ready low: pipe absorbs exactly 4 beats
        for (int c = 0; c < 8; c++) begin
            drive_b(1, 32'hA0 + ((c < 4) ? c : 4));
            tick();
            chk("t2_srdy", sb.ready, c < 3);
            chk("t2_mvld", mb.valid, c >= 1);
            if (c >= 1) chk("t2_mdata", mb.data, 32'hA0);
            chk("t2_occ", occ_b, occ_x((c + 1 < 4) ? c + 1 : 4));
        end
        drive_b(0, 0);
        mb.ready = 1'b1;
        got = 0;
        for (int i = 0; i < 12; i++) begin
            if (mb.valid) begin
                chk("t2_drain", mb.data, 32'hA0 + got);
                got++;
            end
            tick();
        end
        chk("t2_count", got, 4);
        chk("t2_empty_srdy", sb.ready, 1);
        chk("t2_empty_occ", occ_b, 0);

        // Flush with 3 beats held, plus a beat presented in the flush cycle
        ma.ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_a(1, 32'h30 + c, 0);
            tick();
        end
        chk("t3_pre_mvld", ma.valid, 1);
        chk("t3_pre_data", ma.data, 32'h30);
        chk("t3_pre_occ", occ_a, occ_x(3));
        flush = 1'b1;
        drive_a(1, 32'h33, 0);
        tick();
        flush = 1'b0;
        drive_a(0, 0, 0);
        chk("t3_mvld", ma.valid, 0);
        chk("t3_occ", occ_a, 0);
        chk("t3_srdy", sa.ready, 1);
        ma.ready = 1'b1;
        drive_a(1, 32'h34, 1);
        tick();
        drive_a(0, 0, 0);
        got = 0;
        for (int i = 0; i < 8; i++) begin
            if (ma.valid) begin
                chk("t3_after", ma.data, 32'h34);
                got++;
            end
            tick();
        end
        chk("t3_count", got, 1);

        // Reset while full
        ma.ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            drive_a(1, 32'h40, 0);
            tick();
        end
        chk("t4_full_srdy", sa.ready, 0);
        chk("t4_full_occ", occ_a, occ_x(6));
        chk("t4_full_mvld", ma.valid, 1);
        rst = 1'b1;
        drive_a(0, 0, 0);
        tick();
        rst = 1'b0;
        chk("t4_mvld", ma.valid, 0);
        chk("t4_srdy", sa.ready, 1);
        chk("t4_occ", occ_a, 0);

        // Delay line, 4 stages, ready ignored, pattern 1,0,1,1
        pat = 4'b1101;
        acc = 0; del = 0; prev_v = 0;
        for (int c = 0; c < 10; c++) begin
            drive_c((c < 4) ? pat[c] : 1'b0, 32'hC0 + c);
            if (c < 4 && pat[c]) acc++;
            if (prev_v == 1) del++;
            tick();
            exp_v = (c >= 3 && c <= 6) ? int'(pat[c-3]) : 0;
            chk("t5_mvld", mc.valid, exp_v);
            if (exp_v == 1) chk("t5_data", mc.data, 32'hC0 + c - 3);
            chk("t5_srdy", sc.ready, 1);
            chk("t5_occ", occ_c, occ_x(acc - del));
            prev_v = exp_v;
        end

        // Random valid/ready, scoreboard against the 3-stage instance
        pend = 1'b0; n_sent = 0; n_recv = 0; cyc = 0;
        while (n_recv < 10000 && cyc < 60000) begin
            if (!pend && $urandom_range(0, 1) == 1) pend = 1'b1;
            drive_a(pend, n_sent, (n_sent % 5) == 4);
            ma.ready = 1'($urandom_range(0, 1));
            s_hs = pend & sa.ready;
            m_hs = ma.valid & ma.ready;
            if (m_hs) begin
                if (exp_q.size() == 0) begin
                    chk("st_spurious", ma.valid, 0);
                end else begin
                    e = int'(exp_q.pop_front());
                    chk("st_data", ma.data, e);
                    chk("st_last", ma.last, (e % 5) == 4);
                    n_recv++;
                end
            end
            if (s_hs) begin
                exp_q.push_back(n_sent);
                n_sent++;
                pend = 1'b0;
            end
            tick();
            chk("st_occ", occ_a, occ_x(exp_q.size()));
            cyc++;
        end
        drive_a(0, 0, 0);
        ma.ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (ma.valid && exp_q.size() > 0) begin
                e = int'(exp_q.pop_front());
                chk("st_drain", ma.data, e);
                n_recv++;
            end
            tick();
        end
        chk("st_left", exp_q.size(), 0);
        chk("st_total", n_recv, n_sent);
        chk("st_end_mvld", ma.valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
